// File: rtl/memory_unit_mmio_if.sv
// memory_unit_mmio_if: CPU read/write bus plus streamed program-load channel
//   we, int_abus, int_wbus -> CPU write enable, address, write data
//   int_rbus               <- registered CPU read data
//   ld_valid, ld_data, ld_last -> load words; ld_ready <- loader accepting
interface memory_unit_mmio_if #(
  parameter int DW = 16,
  parameter int AW = 16
);
  logic          we;
  logic [AW-1:0] int_abus;
  logic [DW-1:0] int_wbus;
  logic [DW-1:0] int_rbus;
  logic          ld_valid;
  logic [DW-1:0] ld_data;
  logic          ld_last;
  logic          ld_ready;
  modport master (
    output we, int_abus, int_wbus, ld_valid, ld_data, ld_last,
    input  int_rbus, ld_ready
  );
  modport slave (
    input  we, int_abus, int_wbus, ld_valid, ld_data, ld_last,
    output int_rbus, ld_ready
  );
endinterface

// File: rtl/memory_unit_mmio.sv
// memory_unit_mmio: word RAM with PSW/port I/O window and streamed program load
//   clk, reset (sync, active-low)
//   bus   : memory_unit_mmio_if.slave (CPU bus + load channel)
//   porta : output ports, port k = [k*DW +: DW]
//   portb : asynchronous input ports, same packing
//   Z     : ALU zero flag, mirrored into psw[DW-1]
//   psw   : PSW register; busy : high while loading
module memory_unit_mmio #(
  parameter int            DW      = 16,
  parameter int            AW      = 16,
  parameter int            NPORT   = 2,
  parameter logic [AW-1:0] IO_BASE = 16'h0FFB
) (
  input  logic                  clk,
  input  logic                  reset,
  memory_unit_mmio_if.slave     bus,
  output logic [NPORT*DW-1:0]   porta,
  input  logic [NPORT*DW-1:0]   portb,
  input  logic                  Z,
  output logic [DW-1:0]         psw,
  output logic                  busy
);
  localparam logic [AW-1:0] IO_TOP = IO_BASE + AW'(2 * NPORT);
  typedef enum logic {LOAD, RUN} state_t;
  state_t              state;
  logic [AW-1:0]       ld_ptr;
  logic [DW-1:0]       mem [2**AW];
  logic [NPORT*DW-1:0] s1, s2, prev, porta_n;
  logic [NPORT-1:0]    chg;
  logic [DW-1:0]       psw_n, io_rd;
  logic [AW-1:0]       off;
  logic                cpu_io, ld_io, ram_we, wr_psw;
  function automatic logic in_io(input logic [AW-1:0] a);
    return a >= IO_BASE && a <= IO_TOP;
  endfunction
  always_comb begin
    off     = bus.int_abus - IO_BASE;
    cpu_io  = in_io(bus.int_abus);
    ld_io   = in_io(ld_ptr);
    ram_we  = reset && (state == LOAD ? bus.ld_valid && !ld_io : bus.we && !cpu_io);
    wr_psw  = state == RUN && bus.we && off == '0;
    io_rd   = psw;
    porta_n = porta;
    psw_n   = psw;
    for (int k = 0; k < NPORT; k++) begin
      chg[k] = s2[k*DW +: DW] != prev[k*DW +: DW];
      if (off == AW'(2*k + 1)) begin
        io_rd = porta[k*DW +: DW];
        if (state == RUN && bus.we) porta_n[k*DW +: DW] = bus.int_wbus;
      end
      if (off == AW'(2*k + 2)) io_rd = s2[k*DW +: DW];
    end
    // low NPORT bits are write-1-to-clear change flags, the rest plain r/w
    for (int i = 0; i < DW; i++)
      if (wr_psw) psw_n[i] = (i < NPORT) ? psw[i] & ~bus.int_wbus[i] : bus.int_wbus[i];
    // a change detected this cycle overrides a simultaneous clear
    for (int k = 0; k < NPORT; k++)
      psw_n[k] = psw_n[k] | chg[k];
    psw_n[DW-1] = state == RUN ? Z : psw[DW-1];
  end
  always_ff @(posedge clk)
    if (ram_we) mem[state == LOAD ? ld_ptr : bus.int_abus] <= state == LOAD ? bus.ld_data : bus.int_wbus;
  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= LOAD;
      ld_ptr       <= '0;
      psw          <= '0;
      porta        <= '0;
      bus.int_rbus <= '0;
      s1           <= '0;
      s2           <= '0;
      prev         <= '0;
      bus.ld_ready <= 1'b1;
      busy         <= 1'b1;
    end else begin
      s1    <= portb;
      s2    <= s1;
      prev  <= s2;
      psw   <= psw_n;
      porta <= porta_n;
      if (state == LOAD) begin
        bus.int_rbus <= '0;
        if (bus.ld_valid) begin
          ld_ptr <= ld_ptr + AW'(1);
          if (bus.ld_last) begin
            state        <= RUN;
            bus.ld_ready <= 1'b0;
            busy         <= 1'b0;
          end
        end
      end else begin
        bus.int_rbus <= cpu_io ? io_rd : mem[bus.int_abus];
      end
    end
  end
endmodule

// File: tb/tb_memory_unit_mmio.sv
// tb_memory_unit_mmio: directed scoreboard bench for memory_unit_mmio
module tb_memory_unit_mmio;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] porta, portb;
  logic        Z;
  logic [15:0] psw;
  logic        busy;
  int          n_asrt = 0;
  int          n_fail = 0;
  logic [15:0] exp_q[$];
  memory_unit_mmio_if #(.DW(16), .AW(16)) bus ();
  memory_unit_mmio dut (
    .clk(clk), .reset(reset), .bus(bus), .porta(porta), .portb(portb),
    .Z(Z), .psw(psw), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    bus.we = 1'b1; bus.int_abus = a; bus.int_wbus = d;
    step();
    bus.we = 1'b0;
  endtask
  task automatic rd(input string tag, input logic [15:0] a, input logic [15:0] exp);
    bus.we = 1'b0; bus.int_abus = a;
    exp_q.push_back(exp);
    step();
    chk(tag, {16'h0, bus.int_rbus}, {16'h0, exp_q.pop_front()});
  endtask
  initial begin
    reset = 1'b0; Z = 1'b0; portb = '0;
    bus.we = 1'b0; bus.int_abus = '0; bus.int_wbus = '0;
    bus.ld_valid = 1'b0; bus.ld_data = '0; bus.ld_last = 1'b0;
    step(); step();
    chk("rst_busy", {31'h0, busy}, 32'h1);
    chk("rst_ready", {31'h0, bus.ld_ready}, 32'h1);
    chk("rst_psw", {16'h0, psw}, 32'h0);
    chk("rst_porta", porta, 32'h0);
    chk("rst_rbus", {16'h0, bus.int_rbus}, 32'h0);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.ld_valid = 1'b1; bus.ld_data = 16'h1111 * 16'(i + 1); bus.ld_last = (i == 3);
      step();
      chk("load_busy", {31'h0, busy}, {31'h0, i < 3});
    end
    bus.ld_valid = 1'b0; bus.ld_last = 1'b0;
    chk("run_ready", {31'h0, bus.ld_ready}, 32'h0);
    rd("rd_ram2", 16'h0002, 16'h3333);
    rd("rd_ram0", 16'h0000, 16'h1111);
    rd("rd_ram3", 16'h0003, 16'h4444);
    wr(16'h0FFC, 16'hA5A5);
    chk("porta0", porta, 32'h0000A5A5);
    rd("rd_porta0", 16'h0FFC, 16'hA5A5);
    portb[31:16] = 16'h00F0;
    step(); chk("chg_e1", {16'h0, psw}, 32'h0);
    step(); chk("chg_e2", {16'h0, psw}, 32'h0);
    step(); chk("chg_e3", {16'h0, psw}, 32'h0002);
    rd("rd_portb1", 16'h0FFF, 16'h00F0);
    portb[31:16] = 16'h00F1;
    step(); step();
    wr(16'h0FFB, 16'h0002);
    chk("set_wins", {16'h0, psw}, 32'h0002);
    step(); step(); step();
    wr(16'h0FFB, 16'h0002);
    chk("w1c_clear", {16'h0, psw}, 32'h0);
    wr(16'h0FFB, 16'h1234);
    chk("psw_rw", {16'h0, psw}, 32'h1234);
    rd("rd_psw", 16'h0FFB, 16'h1234);
    wr(16'h0FFB, 16'h0000);
    wr(16'h0010, 16'h0F0F);
    bus.we = 1'b1; bus.int_abus = 16'h0010; bus.int_wbus = 16'hBEEF;
    exp_q.push_back(16'h0F0F);
    step();
    bus.we = 1'b0;
    chk("rbw_old", {16'h0, bus.int_rbus}, {16'h0, exp_q.pop_front()});
    rd("rbw_new", 16'h0010, 16'hBEEF);
    Z = 1'b1;
    step();
    chk("z_flag", {16'h0, psw}, 32'h8000);
    wr(16'h0FFB, 16'h0000);
    chk("z_owns_msb", {16'h0, psw}, 32'h8000);
    reset = 1'b0; Z = 1'b0;
    bus.ld_valid = 1'b1; bus.ld_data = 16'h9999;
    step();
    bus.ld_valid = 1'b0;
    chk("mid_rst_psw", {16'h0, psw}, 32'h0);
    chk("mid_rst_porta", porta, 32'h0);
    chk("mid_rst_busy", {31'h0, busy}, 32'h1);
    reset = 1'b1;
    wr(16'h0010, 16'hDEAD);
    chk("load_rbus0", {16'h0, bus.int_rbus}, 32'h0);
    bus.ld_valid = 1'b1; bus.ld_data = 16'h7777; bus.ld_last = 1'b1;
    step();
    bus.ld_valid = 1'b0; bus.ld_last = 1'b0;
    chk("reload_busy", {31'h0, busy}, 32'h0);
    rd("ram_kept", 16'h0010, 16'hBEEF);
    rd("reload_w0", 16'h0000, 16'h7777);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
